// File: rtl/imgproc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imgproc_pkg
//   Shared types and helpers for the image-processing controllers: sequencer
//   state encoding, core operation codes, default widths, {r,g,b} packing.
//   Revision: 1.0
// ----------------------------------------------------------------------------
package imgproc_pkg;

  localparam int PIX_W_DEF  = 24;
  localparam int ADDR_W_DEF = 16;

  // Core operation codes
  localparam logic [2:0] OP_PASS   = 3'b000;
  localparam logic [2:0] OP_BRIGHT = 3'b001;
  localparam logic [2:0] OP_THRESH = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WT   = 3'd2,
    ST_ISS  = 3'd3,
    ST_WC   = 3'd4,
    ST_WR   = 3'd5,
    ST_DONE = 3'd6,
    ST_ERR  = 3'd7
  } seq_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic [23:0] pack_rgb(input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
    return {r, g, b};
  endfunction

  function automatic rgb_t unpack_rgb(input logic [23:0] p);
    return rgb_t'(p);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_sequencer_if
//   Control, source-RAM, core and destination-RAM signals of the frame
//   sequencer. master = sequencer side, slave = surrounding system.
//   Revision: 1.0
// ----------------------------------------------------------------------------
interface frame_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 24
);
  // control
  logic              start;
  logic [2:0]        select_oper_in;
  logic [7:0]        bright_val_in;
  logic [7:0]        threshold_in;
  // source RAM
  logic              src_en;
  logic [ADDR_W-1:0] src_addr;
  logic [PIX_W-1:0]  src_douta;
  // core
  logic [2:0]        core_select_oper;
  logic [7:0]        core_bright_val;
  logic [7:0]        core_threshold;
  logic              core_done_in;
  logic [7:0]        core_red_in;
  logic [7:0]        core_green_in;
  logic [7:0]        core_blue_in;
  logic              core_done_out;
  logic [7:0]        core_red_out;
  logic [7:0]        core_green_out;
  logic [7:0]        core_blue_out;
  // destination RAM
  logic              dst_en;
  logic              dst_we;
  logic [ADDR_W-1:0] dst_addr;
  logic [PIX_W-1:0]  dst_dina;
  // status
  logic              busy;
  logic              frame_done;
  logic              timeout_err;
  logic [ADDR_W-1:0] pixel_cnt;

  modport master (
    input  start, select_oper_in, bright_val_in, threshold_in,
    output src_en, src_addr,
    input  src_douta,
    output core_select_oper, core_bright_val, core_threshold,
    output core_done_in, core_red_in, core_green_in, core_blue_in,
    input  core_done_out, core_red_out, core_green_out, core_blue_out,
    output dst_en, dst_we, dst_addr, dst_dina,
    output busy, frame_done, timeout_err, pixel_cnt
  );

  modport slave (
    output start, select_oper_in, bright_val_in, threshold_in,
    input  src_en, src_addr,
    output src_douta,
    input  core_select_oper, core_bright_val, core_threshold,
    input  core_done_in, core_red_in, core_green_in, core_blue_in,
    output core_done_out, core_red_out, core_green_out, core_blue_out,
    input  dst_en, dst_we, dst_addr, dst_dina,
    input  busy, frame_done, timeout_err, pixel_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pixel_watchdog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pixel_watchdog
//   Loadable down-counter. expired_o flags the decrement that would take the
//   count to zero, so a load of N allows exactly N decrement cycles.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module pixel_watchdog #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load_i,
  input  wire logic [WIDTH-1:0] load_val_i,
  input  wire logic             dec_i,
  output logic                  expired_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement; decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = dec_i && !load_i && (cnt_q <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_sequencer
//   Streams every source pixel through the processing core and writes each
//   result to the destination RAM, one pixel at a time, with a per-pixel
//   watchdog on the core response.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module frame_sequencer
  import imgproc_pkg::*;
#(
  parameter int PIXELS  = 41749,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int PIX_W   = PIX_W_DEF,
  parameter int RAM_LAT = 1,
  parameter int TIMEOUT = 255
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  frame_sequencer_if.master  bus
);

  localparam int                WD_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_LOAD   = WD_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS);
  localparam logic [1:0]        WAIT_LOAD = 2'(RAM_LAT - 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        wait_q, wait_d;
  logic [2:0]        sel_q, sel_d;
  logic [7:0]        bright_q, bright_d;
  logic [7:0]        thr_q, thr_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [PIX_W-1:0]  dst_q, dst_d;
  logic              terr_q, terr_d;

  logic              wd_load;
  logic              wd_dec;
  logic              wd_expired;
  rgb_t              pix_rgb;

  pixel_watchdog #(
    .WIDTH (WD_W)
  ) u_watchdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (wd_load),
    .load_val_i (WD_LOAD),
    .dec_i      (wd_dec),
    .expired_o  (wd_expired)
  );

  // Next-state and datapath updates for the per-pixel read/issue/write loop
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    sel_d    = sel_q;
    bright_d = bright_q;
    thr_d    = thr_q;
    pix_d    = pix_q;
    dst_d    = dst_q;
    terr_d   = terr_q;
    wd_load  = 1'b0;
    wd_dec   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sel_d    = bus.select_oper_in;
          bright_d = bus.bright_val_in;
          thr_d    = bus.threshold_in;
          addr_d   = '0;
          cnt_d    = '0;
          terr_d   = 1'b0;
          state_d  = ST_RD;
        end
      end
      ST_RD: begin
        wait_d  = WAIT_LOAD;
        state_d = ST_WT;
      end
      ST_WT: begin
        // RAM data is valid in the last wait cycle; hold it for the core
        if (wait_q == 2'd0) begin
          pix_d   = bus.src_douta;
          state_d = ST_ISS;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      ST_ISS: begin
        wd_load = 1'b1;
        state_d = ST_WC;
      end
      ST_WC: begin
        if (bus.core_done_out) begin
          dst_d   = pack_rgb(bus.core_red_out, bus.core_green_out, bus.core_blue_out);
          state_d = ST_WR;
        end else begin
          wd_dec = 1'b1;
          if (wd_expired) begin
            terr_d  = 1'b1;
            state_d = ST_ERR;
          end
        end
      end
      ST_WR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      sel_q    <= '0;
      bright_q <= '0;
      thr_q    <= '0;
      pix_q    <= '0;
      dst_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      sel_q    <= sel_d;
      bright_q <= bright_d;
      thr_q    <= thr_d;
      pix_q    <= pix_d;
      dst_q    <= dst_d;
      terr_q   <= terr_d;
    end
  end

  assign pix_rgb = unpack_rgb(pix_q);

  assign bus.src_en           = (state_q == ST_RD);
  assign bus.src_addr         = addr_q;
  assign bus.core_select_oper = sel_q;
  assign bus.core_bright_val  = bright_q;
  assign bus.core_threshold   = thr_q;
  assign bus.core_done_in     = (state_q == ST_ISS);
  assign bus.core_red_in      = pix_rgb.r;
  assign bus.core_green_in    = pix_rgb.g;
  assign bus.core_blue_in     = pix_rgb.b;
  assign bus.dst_en           = (state_q == ST_WR);
  assign bus.dst_we           = (state_q == ST_WR);
  assign bus.dst_addr         = addr_q;
  assign bus.dst_dina         = dst_q;
  assign bus.busy             = (state_q == ST_RD)  || (state_q == ST_WT) ||
                                (state_q == ST_ISS) || (state_q == ST_WC) ||
                                (state_q == ST_WR);
  assign bus.frame_done       = (state_q == ST_DONE);
  assign bus.timeout_err      = terr_q;
  assign bus.pixel_cnt        = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_frame_sequencer
//   Two sequencers (RAM latency 1 and 3) driven with the same frames; a
//   behavioural core and RAM surround each, a scoreboard checks all writes.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module tb_frame_sequencer;
  import imgproc_pkg::*;

  localparam int P    = 5;
  localparam int NPIX = P + 1;
  localparam int TMO  = 4;
  localparam int ND   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [2:0]  sel;
  logic [7:0]  bright;
  logic [7:0]  thr;
  int          withhold;
  logic [23:0] src_mem [NPIX];

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [2:0]  exp_sel;
  logic [39:0] exp_q [ND][$];

  wire         w_we   [ND];
  wire         w_din  [ND];
  wire         w_fd   [ND];
  wire         w_busy [ND];
  wire         w_terr [ND];
  wire         w_zero [ND];
  wire [15:0]  w_addr [ND];
  wire [15:0]  w_pcnt [ND];
  wire [23:0]  w_dina [ND];
  wire [2:0]   w_sel  [ND];

  // Behaviour of the processing core, from its operation definitions
  function automatic logic [23:0] core_fn(input logic [23:0] p, input logic [2:0] op,
                                          input logic [7:0] th, input logic [7:0] br);
    int s;
    logic [23:0] r;
    r = p;
    if (op == OP_THRESH) begin
      s = (int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0])) / 3;
      r = (s >= int'(th)) ? 24'hFFFFFF : 24'h000000;
    end else if (op == OP_BRIGHT) begin
      for (int c = 0; c < 3; c++) begin
        s = int'(p[c*8 +: 8]) + int'(br);
        r[c*8 +: 8] = (s > 255) ? 8'hFF : 8'(s);
      end
    end
    return r;
  endfunction

  function automatic void check(input int k, input string name,
                                input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL dut%0d %s: got %0h, expected %0h", k, name, act, req);
  endfunction

  for (genvar k = 0; k < ND; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 1 : 3;

    frame_sequencer_if #(.ADDR_W(16), .PIX_W(24)) ifc ();

    frame_sequencer #(
      .PIXELS (P), .ADDR_W (16), .PIX_W (24), .RAM_LAT (LAT), .TIMEOUT (TMO)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.master)
    );

    assign ifc.start          = start;
    assign ifc.select_oper_in = sel;
    assign ifc.bright_val_in  = bright;
    assign ifc.threshold_in   = thr;

    assign w_we[k]   = ifc.dst_we;
    assign w_din[k]  = ifc.core_done_in;
    assign w_fd[k]   = ifc.frame_done;
    assign w_busy[k] = ifc.busy;
    assign w_terr[k] = ifc.timeout_err;
    assign w_addr[k] = ifc.dst_addr;
    assign w_pcnt[k] = ifc.pixel_cnt;
    assign w_dina[k] = ifc.dst_dina;
    assign w_sel[k]  = ifc.core_select_oper;
    assign w_zero[k] = ~|{ifc.src_en, ifc.src_addr, ifc.core_select_oper, ifc.core_bright_val,
                          ifc.core_threshold, ifc.core_done_in, ifc.core_red_in,
                          ifc.core_green_in, ifc.core_blue_in, ifc.dst_en, ifc.dst_we,
                          ifc.dst_addr, ifc.dst_dina, ifc.busy, ifc.frame_done,
                          ifc.timeout_err, ifc.pixel_cnt};

    // Source RAM: data appears LAT cycles after the read request
    initial begin
      int rd_addr;
      int rd_left;
      rd_addr = 0;
      rd_left = 0;
      ifc.src_douta = '0;
      forever begin
        @(negedge clk);
        if (rst_n && ifc.src_en) begin
          rd_addr = int'(ifc.src_addr);
          rd_left = LAT;
        end
        @(posedge clk);
        #1;
        if (!rst_n) rd_left = 0;
        else if (rd_left > 0) begin
          rd_left--;
          if (rd_left == 0) ifc.src_douta = (rd_addr < NPIX) ? src_mem[rd_addr] : 24'hDEAD00;
        end
      end
    end

    // Core: answers one cycle after done_in, except for the withheld pixel
    initial begin
      logic        pend;
      logic [23:0] res;
      int          idx;
      pend = 1'b0;
      res  = '0;
      idx  = 0;
      ifc.core_done_out = 1'b0;
      {ifc.core_red_out, ifc.core_green_out, ifc.core_blue_out} = '0;
      forever begin
        @(negedge clk);
        if (!rst_n || !ifc.busy) begin
          pend = 1'b0;
          idx  = 0;
        end
        if (rst_n && ifc.core_done_in) begin
          pend = (idx != withhold);
          res  = core_fn({ifc.core_red_in, ifc.core_green_in, ifc.core_blue_in},
                         ifc.core_select_oper, ifc.core_threshold, ifc.core_bright_val);
          idx++;
        end
        @(posedge clk);
        #1;
        ifc.core_done_out = pend && rst_n;
        if (pend) {ifc.core_red_out, ifc.core_green_out, ifc.core_blue_out} = res;
        pend = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  int   last_din [ND];
  int   bcnt     [ND];
  logic bprev    [ND];
  logic tprev    [ND];

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < ND; k++) begin
      int per;
      logic [39:0] e;
      per = 4 + ((k == 0) ? 1 : 3);
      if (!rst_n) begin
        last_din[k] = -1;
        bcnt[k]     = 0;
        bprev[k]    = 1'b0;
        tprev[k]    = 1'b0;
      end else begin
        if (w_busy[k]) bcnt[k] = bprev[k] ? bcnt[k] + 1 : 1;
        if (w_we[k]) begin
          if (exp_q[k].size() == 0) begin
            check(k, "write_expected_queue_size", 64'(exp_q[k].size()), 1);
          end else begin
            e = exp_q[k].pop_front();
            check(k, "dst_addr_data", {w_addr[k], w_dina[k]}, e);
          end
        end
        if (w_din[k]) begin
          check(k, "core_select_oper", w_sel[k], exp_sel);
          if (last_din[k] >= 0) check(k, "pixel_period", cyc - last_din[k], per);
          last_din[k] = cyc;
        end
        if (w_fd[k]) begin
          check(k, "frame_pixel_cnt", w_pcnt[k], NPIX);
          check(k, "busy_cycles", bcnt[k], per * NPIX);
          last_din[k] = -1;
        end
        if (w_terr[k] && !tprev[k]) begin
          check(k, "timeout_delay", cyc - last_din[k], TMO + 1);
          check(k, "busy_at_err", w_busy[k], 0);
          check(k, "pixel_cnt_at_err", w_pcnt[k], withhold);
          last_din[k] = -1;
        end
        bprev[k] = w_busy[k];
        tprev[k] = w_terr[k];
      end
    end
  end

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) src_mem[i] = 24'($urandom);
  endtask

  task automatic start_frame(input logic [2:0] op, input logic [7:0] th,
                             input logic [7:0] br, input int wh);
    @(negedge clk);
    sel      = op;
    thr      = th;
    bright   = br;
    withhold = wh;
    exp_sel  = op;
    for (int i = 0; i < NPIX; i++) begin
      if (wh < 0 || i < wh) begin
        for (int k = 0; k < ND; k++) exp_q[k].push_back({16'(i), core_fn(src_mem[i], op, th, br)});
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int wh);
    int n;
    n = 0;
    while ((w_busy[0] || w_busy[1]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(0, "frame_finished", (n < 300), 1);
    for (int k = 0; k < ND; k++) begin
      check(k, "queue_drained", 64'(exp_q[k].size()), 0);
      check(k, "end_pixel_cnt", w_pcnt[k], (wh < 0) ? NPIX : wh);
      check(k, "end_timeout_err", w_terr[k], (wh >= 0));
    end
  endtask

  initial begin
    int n;
    int seen;
    logic [2:0] ops [3];
    ops[0] = OP_PASS; ops[1] = OP_BRIGHT; ops[2] = OP_THRESH;

    rst_n    = 1'b0;
    start    = 1'b0;
    sel      = '0;
    bright   = '0;
    thr      = '0;
    withhold = -1;
    exp_sel  = '0;
    fill_random();
    repeat (3) @(negedge clk);
    for (int k = 0; k < ND; k++) check(k, "reset_outputs_zero", w_zero[k], 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Echo frame with boundary pixel values
    src_mem[0] = 24'h000000; src_mem[1] = 24'h102030;
    src_mem[2] = 24'hFFFFFF; src_mem[3] = 24'h808080;
    start_frame(OP_PASS, 8'd0, 8'd0, -1);
    wait_idle(-1);

    // Threshold frame
    fill_random();
    src_mem[0] = 24'h5A5A5A; src_mem[1] = 24'h101010;
    start_frame(OP_THRESH, 8'd80, 8'd0, -1);
    wait_idle(-1);

    // Start pulse mid-frame with a different code is ignored
    fill_random();
    start_frame(OP_THRESH, 8'($urandom), 8'($urandom), -1);
    repeat (8) @(negedge clk);
    sel   = OP_BRIGHT;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sel   = OP_THRESH;
    wait_idle(-1);

    // Core never answers pixel 2
    fill_random();
    start_frame(OP_PASS, 8'd0, 8'd0, 2);
    wait_idle(2);

    // Next start clears the sticky error
    fill_random();
    start_frame(OP_BRIGHT, 8'($urandom), 8'($urandom), -1);
    for (int k = 0; k < ND; k++) check(k, "timeout_err_cleared", w_terr[k], 0);
    wait_idle(-1);

    // Reset while waiting on the core for pixel 1
    fill_random();
    start_frame(OP_PASS, 8'd0, 8'd0, -1);
    n = 0;
    seen = 0;
    while (seen < 2 && n < 100) begin
      if (w_din[0]) seen++;
      if (seen < 2) begin
        @(negedge clk);
        n++;
      end
    end
    check(0, "reached_pixel1_issue", (seen == 2), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      check(k, "midframe_reset_outputs_zero", w_zero[k], 1);
      exp_q[k].delete();
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Random frames after the abandoned one
    for (int f = 0; f < 3; f++) begin
      fill_random();
      start_frame(ops[$urandom_range(0, 2)], 8'($urandom), 8'($urandom), -1);
      wait_idle(-1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
